// File: rtl/mdu_req_ctrl_if.sv
// Pipeline-side and MDU-side signals of the MDU request controller.
// With MDU_DIV0_TRAP_EN defined, the divide-by-zero pulse div0 is added.
interface mdu_req_ctrl_if;
    logic        in_valid;
    logic [3:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        stall;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        err;
    logic        mdu_start;
    logic [3:0]  mdu_op;
    logic [31:0] mdu_a;
    logic [31:0] mdu_b;
    logic        mdu_busy;
    logic [31:0] mdu_hi;
    logic [31:0] mdu_lo;
`ifdef MDU_DIV0_TRAP_EN
    logic        div0;

    modport slave (
        input  in_valid, in_op, in_a, in_b, mdu_busy, mdu_hi, mdu_lo,
        output stall, rd_valid, rd_data, err, mdu_start, mdu_op, mdu_a, mdu_b, div0
    );
    modport master (
        output in_valid, in_op, in_a, in_b, mdu_busy, mdu_hi, mdu_lo,
        input  stall, rd_valid, rd_data, err, mdu_start, mdu_op, mdu_a, mdu_b, div0
    );
`else
    modport slave (
        input  in_valid, in_op, in_a, in_b, mdu_busy, mdu_hi, mdu_lo,
        output stall, rd_valid, rd_data, err, mdu_start, mdu_op, mdu_a, mdu_b
    );
    modport master (
        output in_valid, in_op, in_a, in_b, mdu_busy, mdu_hi, mdu_lo,
        input  stall, rd_valid, rd_data, err, mdu_start, mdu_op, mdu_a, mdu_b
    );
`endif
endinterface

// File: rtl/mdu_req_ctrl.sv
// MDU request controller: one-entry request buffer, MDU issue FSM, HI/LO read-back and
// busy watchdog. Optional macro MDU_DIV0_TRAP_EN drops div/divu by zero and pulses div0.
module mdu_req_ctrl #(
    parameter int unsigned TIMEOUT = 31,
    parameter int unsigned CNT_W   = 5
) (
    input logic           clk_i,
    input logic           rst_ni,
    mdu_req_ctrl_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StIssue, StArm, StWait} state_e;

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpDiv   = 4'd2;
    localparam logic [3:0] OpMthi  = 4'd3;
    localparam logic [3:0] OpMtlo  = 4'd4;
    localparam logic [3:0] OpMultu = 4'd5;
    localparam logic [3:0] OpDivu  = 4'd6;
    localparam logic [3:0] OpMfhi  = 4'd7;
    localparam logic [3:0] OpMflo  = 4'd8;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OpMult) || (op == OpDiv) || (op == OpMultu) || (op == OpDivu);
    endfunction

    function automatic logic is_mt(input logic [3:0] op);
        return (op == OpMthi) || (op == OpMtlo);
    endfunction

    function automatic logic is_mf(input logic [3:0] op);
        return (op == OpMfhi) || (op == OpMflo);
    endfunction

    state_e           state_q, state_d;
    logic             req_vld_q, req_vld_d;
    logic [3:0]       req_op_q, req_op_d;
    logic [31:0]      req_a_q, req_a_d;
    logic [31:0]      req_b_q, req_b_d;
    logic             mdu_start_q, mdu_start_d;
    logic [3:0]       mdu_op_q, mdu_op_d;
    logic [31:0]      mdu_a_q, mdu_a_d;
    logic [31:0]      mdu_b_q, mdu_b_d;
    logic             rd_valid_q, rd_valid_d;
    logic [31:0]      rd_data_q, rd_data_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic [CNT_W-1:0] wd_inc;
    logic             issue_ok;
    logic             div0_hit;
    logic             wd_expired;

    assign issue_ok   = (state_q == StIdle) && req_vld_q && !bus.mdu_busy;
    assign wd_inc     = wd_q + CNT_W'(1);
    assign wd_expired = (wd_inc == CNT_W'(TIMEOUT));

`ifdef MDU_DIV0_TRAP_EN
    logic div0_q, div0_d;
    assign div0_hit = ((req_op_q == OpDiv) || (req_op_q == OpDivu)) && (req_b_q == '0);
    assign bus.div0 = div0_q;
`else
    assign div0_hit = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (issue_ok && !div0_hit && (is_muldiv(req_op_q) || is_mt(req_op_q))) begin
                    state_d = StIssue;
                end
            end
            // mdu_op still holds the issued op during ISSUE
            StIssue: state_d = is_mt(mdu_op_q) ? StIdle : StArm;
            StArm:   state_d = StWait;
            StWait: begin
                if (!bus.mdu_busy || wd_expired) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs and datapath next state
    always_comb begin
        req_vld_d   = req_vld_q;
        req_op_d    = req_op_q;
        req_a_d     = req_a_q;
        req_b_d     = req_b_q;
        mdu_start_d = 1'b0;
        mdu_op_d    = mdu_op_q;
        mdu_a_d     = mdu_a_q;
        mdu_b_d     = mdu_b_q;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        err_d       = err_q;
        wd_d        = wd_q;
`ifdef MDU_DIV0_TRAP_EN
        div0_d      = 1'b0;
`endif

        // NOP codes are accepted but never enter the buffer
        if (bus.in_valid && !req_vld_q &&
            (is_muldiv(bus.in_op) || is_mt(bus.in_op) || is_mf(bus.in_op))) begin
            req_vld_d = 1'b1;
            req_op_d  = bus.in_op;
            req_a_d   = bus.in_a;
            req_b_d   = bus.in_b;
        end

        if (issue_ok) begin
            req_vld_d = 1'b0;
            if (div0_hit) begin
`ifdef MDU_DIV0_TRAP_EN
                div0_d = 1'b1;
`endif
            end else if (is_muldiv(req_op_q)) begin
                mdu_start_d = 1'b1;
                mdu_op_d    = req_op_q;
                mdu_a_d     = req_a_q;
                mdu_b_d     = req_b_q;
            end else if (is_mt(req_op_q)) begin
                mdu_op_d = req_op_q;
                mdu_a_d  = req_a_q;
            end else begin
                rd_valid_d = 1'b1;
                rd_data_d  = (req_op_q == OpMfhi) ? bus.mdu_hi : bus.mdu_lo;
            end
        end

        if (state_q == StIssue) begin
            mdu_op_d = 4'd0;
        end

        if (state_q == StWait) begin
            if (bus.mdu_busy && !wd_expired) begin
                wd_d = wd_inc;
            end else begin
                wd_d = '0;
                if (bus.mdu_busy) begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_vld_q   <= 1'b0;
            req_op_q    <= 4'd0;
            req_a_q     <= 32'd0;
            req_b_q     <= 32'd0;
            mdu_start_q <= 1'b0;
            mdu_op_q    <= 4'd0;
            mdu_a_q     <= 32'd0;
            mdu_b_q     <= 32'd0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= 32'd0;
            err_q       <= 1'b0;
            wd_q        <= '0;
`ifdef MDU_DIV0_TRAP_EN
            div0_q      <= 1'b0;
`endif
        end else begin
            req_vld_q   <= req_vld_d;
            req_op_q    <= req_op_d;
            req_a_q     <= req_a_d;
            req_b_q     <= req_b_d;
            mdu_start_q <= mdu_start_d;
            mdu_op_q    <= mdu_op_d;
            mdu_a_q     <= mdu_a_d;
            mdu_b_q     <= mdu_b_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            err_q       <= err_d;
            wd_q        <= wd_d;
`ifdef MDU_DIV0_TRAP_EN
            div0_q      <= div0_d;
`endif
        end
    end

    assign bus.stall     = req_vld_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.err       = err_q;
    assign bus.mdu_start = mdu_start_q;
    assign bus.mdu_op    = mdu_op_q;
    assign bus.mdu_a     = mdu_a_q;
    assign bus.mdu_b     = mdu_b_q;

endmodule

// File: tb/tb_mdu_req_ctrl.sv
// Bench for mdu_req_ctrl: stub MDU with a stuck-busy mode and a scoreboard of expected
// HI/LO read results popped on each rd_valid pulse.
module tb_mdu_req_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mdu_req_ctrl_if u_if ();

    mdu_req_ctrl #(
        .TIMEOUT(31),
        .CNT_W  (5)
    ) u_dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (u_if)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Stub MDU: busy for four cycles after start; stuck freezes it busy
    logic        stub_busy = 1'b0;
    logic        stuck     = 1'b0;
    logic        pend      = 1'b0;
    logic [31:0] hi_q      = 32'd0;
    logic [31:0] lo_q      = 32'd0;
    logic [63:0] res_q     = 64'd0;
    int          cnt_q     = 0;

    assign u_if.mdu_busy = stub_busy;
    assign u_if.mdu_hi   = hi_q;
    assign u_if.mdu_lo   = lo_q;

    function automatic logic [63:0] mdu_calc(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [63:0] r;
        r = 64'd0;
        case (op)
            4'd1: r = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            4'd5: r = {32'd0, a} * {32'd0, b};
            4'd2: if (b != 0) r = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
            4'd6: if (b != 0) r = {a % b, a / b};
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        if (u_if.mdu_start) begin
            stub_busy <= 1'b1;
            cnt_q     <= 4;
            pend      <= 1'b1;
            res_q     <= mdu_calc(u_if.mdu_op, u_if.mdu_a, u_if.mdu_b);
        end else if (stub_busy && !stuck) begin
            if (cnt_q <= 1) begin
                stub_busy <= 1'b0;
                pend      <= 1'b0;
                if (pend) begin
                    hi_q <= res_q[63:32];
                    lo_q <= res_q[31:0];
                end
            end else begin
                cnt_q <= cnt_q - 1;
            end
        end
        if (!u_if.mdu_start && u_if.mdu_op == 4'd3) hi_q <= u_if.mdu_a;
        if (!u_if.mdu_start && u_if.mdu_op == 4'd4) lo_q <= u_if.mdu_a;
    end

    // Monitor and scoreboard
    logic [31:0] exp_q[$];
    int          start_cnt = 0;
    int          op_cnt    = 0;
    int          rd_cnt    = 0;
    int          div0_cnt  = 0;
    logic [3:0]  last_op   = 4'd0;
    logic        busy_prev = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (u_if.mdu_start) start_cnt++;
            if (u_if.mdu_op != 4'd0) begin
                op_cnt++;
                last_op = u_if.mdu_op;
            end
`ifdef MDU_DIV0_TRAP_EN
            if (u_if.div0) div0_cnt++;
`endif
            if (u_if.rd_valid) begin
                rd_cnt++;
                check_eq("rd_while_busy", 32'(busy_prev), 32'd0);
                if (exp_q.size() == 0) begin
                    check_eq("rd_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    check_eq("rd_data", u_if.rd_data, exp_q.pop_front());
                end
            end
        end
        busy_prev = u_if.mdu_busy;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_cnt();
        start_cnt = 0;
        op_cnt    = 0;
        rd_cnt    = 0;
        div0_cnt  = 0;
        last_op   = 4'd0;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic exp_stall);
        int n;
        n = 0;
        while (u_if.stall && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (u_if.stall) check_eq("send_timeout", 32'(u_if.stall), 32'd0);
        u_if.in_valid = 1'b1;
        u_if.in_op    = op;
        u_if.in_a     = a;
        u_if.in_b     = b;
        @(negedge clk);
        u_if.in_valid = 1'b0;
        check_eq("stall_after_accept", 32'(u_if.stall), 32'(exp_stall));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200us");
        $fatal(1);
    end

    initial begin
        u_if.in_valid = 1'b0;
        u_if.in_op    = 4'd0;
        u_if.in_a     = 32'd0;
        u_if.in_b     = 32'd0;

        // Reset state
        #3 rst_n = 1'b0;
        #1;
        check_eq("rst_stall", 32'(u_if.stall), 32'd0);
        check_eq("rst_rd_valid", 32'(u_if.rd_valid), 32'd0);
        check_eq("rst_rd_data", u_if.rd_data, 32'd0);
        check_eq("rst_err", 32'(u_if.err), 32'd0);
        check_eq("rst_start", 32'(u_if.mdu_start), 32'd0);
        check_eq("rst_op", 32'(u_if.mdu_op), 32'd0);
        check_eq("rst_a", u_if.mdu_a, 32'd0);
        check_eq("rst_b", u_if.mdu_b, 32'd0);
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(2);

        // NOP codes are dropped
        clr_cnt();
        send(4'd0, 32'h1, 32'h1, 1'b0);
        send(4'd9, 32'h1, 32'h1, 1'b0);
        send(4'd15, 32'h1, 32'h1, 1'b0);
        wait_cyc(4);
        check_eq("nop_op_cycles", 32'(op_cnt), 32'd0);

        // mthi then mfhi
        clr_cnt();
        send(4'd3, 32'h12345678, 32'h0, 1'b1);
        wait_cyc(4);
        check_eq("mthi_op_cycles", 32'(op_cnt), 32'd1);
        check_eq("mthi_op_value", 32'(last_op), 32'd3);
        check_eq("mthi_start", 32'(start_cnt), 32'd0);
        exp_q.push_back(32'h12345678);
        send(4'd7, 32'h0, 32'h0, 1'b1);
        wait_cyc(4);
        check_eq("mfhi_rd_cnt", 32'(rd_cnt), 32'd1);

        // Signed mult, then mflo/mfhi back to back
        clr_cnt();
        send(4'd1, 32'hFFFFFFFF, 32'd2, 1'b1);
        exp_q.push_back(32'hFFFFFFFE);
        send(4'd8, 32'h0, 32'h0, 1'b1);
        exp_q.push_back(32'hFFFFFFFF);
        send(4'd7, 32'h0, 32'h0, 1'b1);
        wait_cyc(15);
        check_eq("mult_start_cycles", 32'(start_cnt), 32'd1);
        check_eq("mult_op_cycles", 32'(op_cnt), 32'd1);
        check_eq("mult_rd_cnt", 32'(rd_cnt), 32'd2);
        check_eq("mult_mdu_a", u_if.mdu_a, 32'hFFFFFFFF);
        check_eq("mult_mdu_b", u_if.mdu_b, 32'd2);

        // divu then mflo/mfhi
        clr_cnt();
        send(4'd6, 32'd100, 32'd7, 1'b1);
        exp_q.push_back(32'd14);
        send(4'd8, 32'h0, 32'h0, 1'b1);
        exp_q.push_back(32'd2);
        send(4'd7, 32'h0, 32'h0, 1'b1);
        wait_cyc(15);
        check_eq("divu_op_cycles", 32'(op_cnt), 32'd1);
        check_eq("divu_op_value", 32'(last_op), 32'd6);
        check_eq("divu_op_idle", 32'(u_if.mdu_op), 32'd0);
        check_eq("divu_rd_cnt", 32'(rd_cnt), 32'd2);

`ifdef MDU_DIV0_TRAP_EN
        // Divide by zero is trapped; LO keeps the divu quotient
        clr_cnt();
        send(4'd2, 32'd5, 32'd0, 1'b1);
        wait_cyc(8);
        check_eq("div0_pulses", 32'(div0_cnt), 32'd1);
        check_eq("div0_start", 32'(start_cnt), 32'd0);
        exp_q.push_back(32'd14);
        send(4'd8, 32'h0, 32'h0, 1'b1);
        wait_cyc(4);
        check_eq("div0_rd_cnt", 32'(rd_cnt), 32'd1);
`endif

        // Reset while waiting on a stuck MDU, with a read buffered
        clr_cnt();
        stuck = 1'b1;
        send(4'd1, 32'd3, 32'd5, 1'b1);
        wait_cyc(6);
        send(4'd7, 32'h0, 32'h0, 1'b1);
        wait_cyc(2);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_stall", 32'(u_if.stall), 32'd0);
        check_eq("midrst_rd_data", u_if.rd_data, 32'd0);
        check_eq("midrst_a", u_if.mdu_a, 32'd0);
        check_eq("midrst_b", u_if.mdu_b, 32'd0);
        check_eq("midrst_err", 32'(u_if.err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("postrst_stall", 32'(u_if.stall), 32'd0);
        check_eq("postrst_rd_cnt", 32'(rd_cnt), 32'd0);
        stuck = 1'b0;
        wait_cyc(10);
        send(4'd3, 32'hCAFE0001, 32'h0, 1'b1);
        exp_q.push_back(32'hCAFE0001);
        send(4'd7, 32'h0, 32'h0, 1'b1);
        wait_cyc(6);

        // Watchdog: busy held forever
        clr_cnt();
        stuck = 1'b1;
        send(4'd1, 32'd1, 32'd1, 1'b1);
        wait_cyc(33);
        check_eq("wd_err_early", 32'(u_if.err), 32'd0);
        @(negedge clk);
        check_eq("wd_err_set", 32'(u_if.err), 32'd1);
        check_eq("wd_start_cycles", 32'(start_cnt), 32'd1);
        stuck = 1'b0;
        wait_cyc(10);
        check_eq("wd_err_sticky", 32'(u_if.err), 32'd1);
        send(4'd4, 32'h0BADF00D, 32'h0, 1'b1);
        exp_q.push_back(32'h0BADF00D);
        send(4'd8, 32'h0, 32'h0, 1'b1);
        wait_cyc(10);
        check_eq("wd_err_still", 32'(u_if.err), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("wd_err_cleared", 32'(u_if.err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cyc(2);

        check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mdu_req_ctrl.md
Name: mdu_req_ctrl

Overview:
- Pipeline-side initiator for the multiply/divide unit: accepts MDU-class instructions from the E stage and drives the MDU's start/op/operand inputs.
- Tracks the MDU busy handshake and returns HI/LO reads for mfhi/mflo.
- Provides a one-entry request buffer, a pipeline stall output and a busy-timeout watchdog.

Parameters:
- TIMEOUT, 31: maximum cycles in WAIT before the error flag is set.
- CNT_W, 5: width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset; clears all state immediately.
- in_valid  in  1  MDU-class instruction presented by the pipeline.
- in_op  in  4  1 mult, 2 div, 3 mthi, 4 mtlo, 5 multu, 6 divu, 7 mfhi, 8 mflo; all other codes are NOP.
- in_a  in  32  rs operand.
- in_b  in  32  rt operand.
- stall  out  1  request buffer full; pipeline must hold the instruction.
- rd_valid  out  1  one-cycle pulse: rd_data holds the mfhi/mflo result.
- rd_data  out  32  captured HI or LO.
- err  out  1  sticky watchdog error flag.
- mdu_start  out  1  to MDU start.
- mdu_op  out  4  to MDU op; 0 whenever not issuing.
- mdu_a  out  32  to MDU operand A.
- mdu_b  out  32  to MDU operand B.
- mdu_busy  in  1  from MDU busy.
- mdu_hi  in  32  from MDU HI.
- mdu_lo  in  32  from MDU LO.

Behaviour:
- Reset (reset=0, async): state=IDLE, req_vld=0, stall=0, rd_valid=0, rd_data=0, err=0, mdu_start=0, mdu_op=0, mdu_a=0, mdu_b=0, watchdog=0. Reset mid-operation abandons the request; the MDU is reset by its own reset.
- Buffer: stall = req_vld (registered, no combinational path from in_*). in_valid && !stall at an edge loads req_op/req_a/req_b and sets req_vld. A NOP op is accepted and dropped (req_vld stays 0).
- Draining at the same edge as a new arrival is not possible: stall is high throughout that cycle.
- All mdu_* outputs are registered.
- FSM states: IDLE, ISSUE, ARM, WAIT.
- IDLE, req_vld, op mult/multu/div/divu, mdu_busy=0:
  - At the edge: mdu_start=1, mdu_op=req_op, mdu_a/mdu_b loaded, req_vld=0, state goes to ISSUE.
- IDLE, req_vld, op mthi/mtlo, mdu_busy=0:
  - At the edge: mdu_start=0, mdu_op=req_op, mdu_a=req_a, req_vld=0, state goes to ISSUE.
- ISSUE (exactly 1 cycle), at the next edge:
  - mdu_start=0, mdu_op=0.
  - mult/div class: state goes to ARM. mthi/mtlo: state goes to IDLE.
- ARM (1 cycle): covers the cycle in which MDU busy is not yet visible; state goes to WAIT unconditionally.
- WAIT: watchdog increments each cycle.
  - Leave to IDLE when mdu_busy=0 is sampled.
  - If the watchdog reaches TIMEOUT: err=1 (sticky) and state goes to IDLE.
  - Watchdog clears on leaving WAIT.
- IDLE, req_vld, op mfhi/mflo, mdu_busy=0: at the edge rd_data=mdu_hi or mdu_lo, rd_valid=1 for one cycle, req_vld=0.
- Any req_vld in IDLE with mdu_busy=1: hold, no issue.
- Latency when idle:
  - mfhi/mflo: accepted at edge N, rd_valid high in the cycle after edge N+1.
  - mthi/mtlo: written into the MDU at edge N+2.
- Operands pass through unmodified; no width changes.

Optional Feature:
- Macro: MDU_DIV0_TRAP_EN.
- Defined: a div or divu with req_b==0 is not issued.
  - Extra output div0 (1 bit) pulses for one cycle at the dropping edge.
  - req_vld clears and state stays IDLE, so HI/LO are unchanged.
- Undefined: the div0 port is absent; divide by zero is issued normally and the MDU result is unspecified.

Test Plan:
- Reset low mid-WAIT -> all outputs 0 immediately (before the next clock edge); after release, state=IDLE and stall=0.
- mthi a=0x12345678, then mfhi -> mdu_op=3 for exactly one cycle with mdu_start=0; rd_valid pulses with rd_data=0x12345678.
- mult a=0xFFFFFFFF, b=2, then mflo and mfhi back-to-back:
  - stall high while each request is buffered.
  - mdu_start high exactly one cycle.
  - No read while mdu_busy=1.
  - rd_data=0xFFFFFFFE, then 0xFFFFFFFF.
- divu a=100, b=7 followed by mflo, mfhi -> rd_data=14, then 2; mdu_op returns to 0 after ISSUE.
- Stub MDU holding busy=1 forever, TIMEOUT=31 -> err=1 after 31 WAIT cycles, state back to IDLE; err stays 1 until reset.
- With MDU_DIV0_TRAP_EN: div b=0 -> div0 pulses one cycle, mdu_start never asserts, following mflo returns the old LO.
